// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants, scan state and position snapshot for the pong row scanner
package pong_pkg;

    localparam int PONG_WIDTH    = 8;
    localparam int PONG_HEIGHT   = 8;
    localparam int PONG_PAD_SIZE = 2;
    localparam int PONG_X_BITS   = 3;
    localparam int PONG_Y_BITS   = 3;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [PONG_X_BITS-1:0] x;
        logic [PONG_Y_BITS-1:0] y;
        logic [PONG_X_BITS-1:0] top;
        logic [PONG_X_BITS-1:0] down;
    } pos_t;

    typedef logic [PONG_X_BITS:0] xw_t;

    // One extra bit so start+len-1 never wraps back into the matrix.
    function automatic logic in_span(input logic [PONG_X_BITS-1:0] start, input int col, input int len);
        xw_t lo;
        xw_t hi;
        xw_t c;
        lo = {1'b0, start};
        hi = lo + xw_t'(len - 1);
        c  = xw_t'(col);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/pong_row_render.sv
// rtl/pong_row_render.sv - combinational column pattern for one matrix row
module pong_row_render
    import pong_pkg::*;
#(
    parameter int WIDTH    = PONG_WIDTH,
    parameter int HEIGHT   = PONG_HEIGHT,
    parameter int PAD_SIZE = PONG_PAD_SIZE
) (
    input  logic [PONG_Y_BITS-1:0] row,
    input  pos_t                   snap,
    input  logic                   ball_en,
    output logic [WIDTH-1:0]       data
);

    always_comb begin
        data = '0;
        // Edge columns are reserved for the ball; paddles only cover 1..WIDTH-2.
        for (int i = 1; i <= WIDTH - 2; i++) begin
            if (row == '0 && in_span(snap.top, i, PAD_SIZE)) begin
                data[WIDTH-1-i] = 1'b1;
            end
            if (row == PONG_Y_BITS'(HEIGHT - 1) && in_span(snap.down, i, PAD_SIZE)) begin
                data[i] = 1'b1;
            end
        end
        if (ball_en && row == snap.y && {1'b0, snap.x} < xw_t'(WIDTH)) begin
            data[snap.x] = 1'b1;
        end
    end

endmodule

// File: rtl/pong_row_scanner.sv
// rtl/pong_row_scanner.sv - tear-free row-scanned LED matrix driver; BALL_BLINK_EN adds ball blinking
module pong_row_scanner
    import pong_pkg::*;
#(
    parameter int WIDTH    = PONG_WIDTH,
    parameter int HEIGHT   = PONG_HEIGHT,
    parameter int X_BITS   = PONG_X_BITS,
    parameter int Y_BITS   = PONG_Y_BITS,
    parameter int PAD_SIZE = PONG_PAD_SIZE,
    parameter int DWELL    = 4
`ifdef BALL_BLINK_EN
    , parameter int BLINK_FRAMES = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic [X_BITS-1:0] x_pos,
    input  logic [Y_BITS-1:0] y_pos,
    input  logic [X_BITS-1:0] player_top,
    input  logic [X_BITS-1:0] player_down,
    input  logic              blank,
    output logic [HEIGHT-1:0] row_sel,
    output logic [WIDTH-1:0]  row_data,
    output logic [Y_BITS-1:0] row_idx,
    output logic              frame_start
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    scan_state_e       state_q, state_d;
    logic [Y_BITS-1:0] row_idx_q, row_idx_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              pending_q, pending_d;
    pos_t              shadow_q, shadow_d;
    pos_t              active_q, active_d;
    logic [HEIGHT-1:0] row_sel_q, row_sel_d;
    logic [WIDTH-1:0]  row_data_q, row_data_d;
    logic              frame_start_q, frame_start_d;
    logic [WIDTH-1:0]  render_data;
    logic              ball_en;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        dwell_d   = dwell_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        case (state_q)
            GAP: begin
                state_d = ON;
                if (row_idx_q == '0 && pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end
            ON: begin
                if (dwell_q == DW'(DWELL - 1)) begin
                    dwell_d   = '0;
                    state_d   = GAP;
                    row_idx_d = (row_idx_q == Y_BITS'(HEIGHT - 1)) ? '0 : row_idx_q + Y_BITS'(1);
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = GAP;
        endcase
        if (pos_valid && !pending_q) begin
            shadow_d  = '{x: x_pos, y: y_pos, top: player_top, down: player_down};
            pending_d = 1'b1;
        end
    end

    assign frame_start_d = (state_d == GAP) && (row_idx_d == '0);

`ifdef BALL_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_start_d) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign ball_en = phase_d;
`else
    assign ball_en = 1'b1;
`endif

    // Render from next-state values so the registered outputs line up with the state they describe.
    pong_row_render #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .PAD_SIZE (PAD_SIZE)
    ) u_render (
        .row     (row_idx_d),
        .snap    (active_d),
        .ball_en (ball_en),
        .data    (render_data)
    );

    always_comb begin
        row_sel_d  = '0;
        row_data_d = '0;
        if (state_d == ON && !blank) begin
            row_sel_d  = {{(HEIGHT-1){1'b0}}, 1'b1} << row_idx_d;
            row_data_d = render_data;
        end
    end

    // frame_start resets high: the first cycle out of reset is the row-0 gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= GAP;
            row_idx_q     <= '0;
            dwell_q       <= '0;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            row_sel_q     <= '0;
            row_data_q    <= '0;
            frame_start_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            dwell_q       <= dwell_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            row_sel_q     <= row_sel_d;
            row_data_q    <= row_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pos_ready   = !pending_q;
    assign row_sel     = row_sel_q;
    assign row_data    = row_data_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pong_row_scanner.sv
// tb/tb_pong_row_scanner.sv - self-checking bench for pong_row_scanner (optionally with BALL_BLINK_EN)
module tb_pong_row_scanner;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int PAD   = 2;
    localparam int D     = 4;
    localparam int P     = H * (D + 1);
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pos_valid = 1'b0;
    logic       pos_ready;
    logic [2:0] x_pos = '0;
    logic [2:0] y_pos = '0;
    logic [2:0] player_top = '0;
    logic [2:0] player_down = '0;
    logic       blank = 1'b0;
    logic [7:0] row_sel;
    logic [7:0] row_data;
    logic [2:0] row_idx;
    logic       frame_start;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int cyc = 0;
    bit model_live = 1'b0;
    bit blank_prev = 1'b0;
    int m_pend = 0;
    int m_sx = 0, m_sy = 0, m_st = 0, m_sd = 0;
    int m_ax = 0, m_ay = 0, m_at = 0, m_ad = 0;

    pong_row_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .player_top  (player_top),
        .player_down (player_down),
        .blank       (blank),
        .row_sel     (row_sel),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ball_vis(input int c);
`ifdef BALL_BLINK_EN
        return ((c / P) / BLINK) % 2 == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] model_row(input int r, input int top, input int down,
                                             input int bx, input int by, input bit ball);
        logic [7:0] v;
        v = '0;
        for (int c = 1; c <= W - 2; c++) begin
            if (r == 0 && c >= top && c < top + PAD) v[W-1-c] = 1'b1;
            if (r == H - 1 && c >= down && c < down + PAD) v[c] = 1'b1;
        end
        if (ball && r == by && bx < W && by < H) v[bx] = 1'b1;
        return v;
    endfunction

    // Reference timeline: cycle 0 is the first cycle after a reset edge.
    always @(posedge clk) begin
        blank_prev <= blank;
        if (rst) begin
            model_live <= 1'b1;
            cyc    <= 0;
            m_pend <= 0;
            m_sx <= 0; m_sy <= 0; m_st <= 0; m_sd <= 0;
            m_ax <= 0; m_ay <= 0; m_at <= 0; m_ad <= 0;
        end else if (model_live) begin
            cyc <= cyc + 1;
            if (cyc % P == 0 && m_pend != 0) begin
                m_ax <= m_sx; m_ay <= m_sy; m_at <= m_st; m_ad <= m_sd;
                m_pend <= 0;
            end
            if (pos_valid && m_pend == 0) begin
                m_sx <= int'(x_pos); m_sy <= int'(y_pos);
                m_st <= int'(player_top); m_sd <= int'(player_down);
                m_pend <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live && !rst) begin
            int p, r;
            bit on;
            logic [7:0] e_sel, e_data;
            p = cyc % P;
            r = p / (D + 1);
            on = (p % (D + 1)) != 0;
            e_sel = '0;
            e_data = '0;
            if (on && !blank) begin
                e_sel = 8'(1 << r);
                e_data = model_row(r, m_at, m_ad, m_ax, m_ay, ball_vis(cyc));
            end
            check("frame_start", frame_start, (p == 0));
            check("row_idx", row_idx, r);
            check("pos_ready", pos_ready, (m_pend == 0));
            if (blank == blank_prev) begin
                check("row_sel", row_sel, e_sel);
                check("row_data", row_data, e_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic until_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 2000) begin
            tick();
            guard++;
        end
        if (cyc != target) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL until_%0d: timed out at cycle %0d", target, cyc);
        end
    endtask

    task automatic offer(input int t, input int d, input int x, input int y);
        pos_valid = 1'b1;
        player_top = 3'(t); player_down = 3'(d); x_pos = 3'(x); y_pos = 3'(y);
    endtask

    initial begin
        logic [15:0] acc;
        int fs_n;

        repeat (3) tick();
        rst = 1'b0;

        // Reset state and an idle frame
        check("rst_frame_start", frame_start, 1);
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_row_data", row_data, 8'h00);
        check("rst_row_idx", row_idx, 0);
        check("rst_pos_ready", pos_ready, 1);
        until_cyc(1);
        check("walk_r0", row_sel, 8'h01);
        check("zero_snap_r0", row_data, 8'b0100_0001);
        until_cyc(5);
        check("gap_r1_sel", row_sel, 8'h00);
        check("gap_r1_idx", row_idx, 1);
        until_cyc(6);
        check("walk_r1", row_sel, 8'h02);
        until_cyc(36);
        check("walk_r7", row_sel, 8'h80);
        check("zero_snap_r7", row_data, 8'b0000_0010);
        until_cyc(40);
        check("frame_period", frame_start, 1);

        // Mid-frame handshake, shown only from the next frame
        until_cyc(50);
        offer(3, 3, 0, 0);
        tick();
        pos_valid = 1'b0;
        check("ready_drops", pos_ready, 0);
        until_cyc(80);
        check("ready_low_at_fs", pos_ready, 0);
        until_cyc(81);
        check("ready_rises", pos_ready, 1);
        check("hs_row0", row_data, 8'b0001_1001);
        until_cyc(116);
        check("hs_row7", row_data, 8'b0001_1000);

        // Capture in the row-0 gap with nothing pending; clipping at the edges
        until_cyc(120);
        offer(1, 6, 5, 3);
        tick();
        pos_valid = 1'b0;
        check("gap_capture_held", row_data, 8'b0001_1001);
        until_cyc(161);
        check("clip_top", row_data, 8'b0110_0000);
        until_cyc(176);
        check("ball_r3", row_data, 8'b0010_0000);
        until_cyc(196);
        check("clip_down", row_data, 8'b0100_0000);

        // pos_valid held while pending: second set waits for pos_ready
        until_cyc(210);
        offer(2, 4, 7, 7);
        tick();
        offer(5, 0, 0, 0);
        until_cyc(241);
        check("held_ready", pos_ready, 1);
        check("held_first_r0", row_data, 8'b0011_0000);
        tick();
        pos_valid = 1'b0;
        check("held_captured", pos_ready, 0);
        until_cyc(276);
        check("held_first_r7", row_data, 8'b1011_0000);
        until_cyc(281);
        check("held_second_r0", row_data, 8'b0000_0111);
        until_cyc(316);
        check("held_second_r7", row_data, 8'b0000_0010);

        // A whole blanked frame
        until_cyc(318);
        blank = 1'b1;
        until_cyc(320);
        acc = '0;
        fs_n = 0;
        for (int k = 0; k < P; k++) begin
            acc = acc | {row_sel, row_data};
            fs_n += int'(frame_start);
            if (k < P - 1) tick();
        end
        blank = 1'b0;
        check("blank_dark", acc, 16'h0000);
        check("blank_fs_count", fs_n, 1);
        until_cyc(360);
        check("blank_fs_period", frame_start, 1);

        // Reset at row 5 with a transfer pending
        until_cyc(380);
        offer(6, 6, 3, 3);
        tick();
        pos_valid = 1'b0;
        until_cyc(387);
        check("pre_rst_pending", pos_ready, 0);
        check("pre_rst_row", row_idx, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_fs", frame_start, 1);
        check("mid_rst_idx", row_idx, 0);
        check("mid_rst_sel", row_sel, 8'h00);
        check("mid_rst_ready", pos_ready, 1);
        until_cyc(1);
        check("mid_rst_snap", row_data, 8'b0100_0001);

        // Ball at (2,3) over frames 1..8
        until_cyc(2);
        offer(3, 3, 2, 3);
        tick();
        pos_valid = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            bit vis;
`ifdef BALL_BLINK_EN
            vis = (f < 4) || (f >= 8);
`else
            vis = 1'b1;
`endif
            until_cyc(f * P + 16);
            check("ball_frame", row_data, vis ? 8'b0000_0100 : 8'b0000_0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
        $fatal(1);
    end

endmodule
